// File: rtl/idma_desc64_ar_arbiter_pkg.sv
// Shared desc64 types: AXI AR channel / ID types and the channel-to-ID mapping
// used by the multi-channel descriptor-fetch read path.
package idma_desc64_ar_arbiter_pkg;

    localparam int unsigned IdWidth = 4;

    typedef logic [IdWidth-1:0] desc64_id_t;

    typedef struct packed {
        desc64_id_t  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } desc64_ar_chan_t;

    // Each channel owns the AXI ID equal to its index.
    function automatic desc64_id_t chan_to_id(input int unsigned idx);
        return desc64_id_t'(idx);
    endfunction

endpackage

// File: rtl/idma_desc64_ar_arbiter_spill.sv
// Two-entry spill register: fully registered valid/data/ready paths, so the
// merged AR channel never changes while it waits for the downstream ready.
module idma_desc64_ar_arbiter_spill #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o
);

    T     a_data_q, b_data_q;
    logic a_full_q, b_full_q;
    logic a_fill_s, a_drain_s, b_fill_s, b_drain_s;

    // Entry B always holds the older beat; A moves into B only when B is empty and stalled.
    assign a_fill_s  = valid_i & ready_o;
    assign a_drain_s = a_full_q & ~b_full_q;
    assign b_fill_s  = a_drain_s & ~ready_i;
    assign b_drain_s = b_full_q & ready_i;

    assign ready_o = ~a_full_q | ~b_full_q;
    assign valid_o = a_full_q | b_full_q;
    assign data_o  = b_full_q ? b_data_q : a_data_q;

    // Entry A state and payload.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_full_q <= 1'b0;
            a_data_q <= '0;
        end else begin
            if (a_fill_s) begin
                a_full_q <= 1'b1;
                a_data_q <= data_i;
            end else if (a_drain_s) begin
                a_full_q <= 1'b0;
            end
        end
    end

    // Entry B state and payload.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_full_q <= 1'b0;
            b_data_q <= '0;
        end else begin
            if (b_fill_s) begin
                b_full_q <= 1'b1;
                b_data_q <= a_data_q;
            end else if (b_drain_s) begin
                b_full_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/idma_desc64_ar_arbiter.sv
// Round-robin AR arbiter for the multi-channel desc64 frontend: fixed per-channel
// AXI IDs and per-channel outstanding-read limits retired on R last.
module idma_desc64_ar_arbiter
    import idma_desc64_ar_arbiter_pkg::*;
#(
    parameter int unsigned  NumChannels    = 4,
    parameter int unsigned  MaxOutstanding = 4,
    parameter type          axi_ar_chan_t  = desc64_ar_chan_t,
    parameter type          axi_id_t       = desc64_id_t,
    localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  axi_ar_chan_t [NumChannels-1:0]        ar_chan_i,
    input  logic         [NumChannels-1:0]        ar_valid_i,
    output logic         [NumChannels-1:0]        ar_ready_o,
    output axi_id_t      [NumChannels-1:0]        chan_id_o,
    output axi_ar_chan_t                          axi_ar_chan_o,
    output logic                                  axi_ar_valid_o,
    input  logic                                  axi_ar_ready_i,
    input  axi_id_t                               axi_r_id_i,
    input  logic                                  axi_r_last_i,
    input  logic                                  axi_r_valid_i,
    input  logic                                  axi_r_ready_i,
    output logic         [NumChannels-1:0][CntW-1:0] outstanding_o,
    output logic                                  busy_o
);

    localparam int unsigned IdxW = (NumChannels > 1) ? $clog2(NumChannels) : 1;

    typedef logic [IdxW-1:0] chan_idx_t;
    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t CntMax = cnt_t'(MaxOutstanding);

    chan_idx_t                  rr_ptr_q, rr_ptr_d, grant_idx_s, idx_s;
    cnt_t [NumChannels-1:0]     cnt_q, cnt_d;
    logic [NumChannels-1:0]     eligible_s, inc_s, dec_s;
    logic                       grant_valid_s, stage_ready_s, grant_hs_s, retire_s;
    axi_ar_chan_t               stage_in_s;

    for (genvar i = 0; i < NumChannels; i++) begin : g_chan_id
        assign chan_id_o[i] = axi_id_t'(chan_to_id(i));
    end

    // Eligibility uses the registered counters only.
    always_comb begin
        eligible_s = '0;
        for (int unsigned i = 0; i < NumChannels; i++) begin
            eligible_s[i] = ar_valid_i[i] & (cnt_q[i] < CntMax);
        end
    end

    // First eligible channel at or after the round-robin pointer, with wrap.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        idx_s         = '0;
        for (int unsigned k = 0; k < NumChannels; k++) begin
            idx_s = chan_idx_t'((32'(rr_ptr_q) + k) % NumChannels);
            if (!grant_valid_s && eligible_s[idx_s]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = idx_s;
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    assign grant_hs_s = grant_valid_s & stage_ready_s;

    // One-hot upstream ready and the ID-rewritten payload for the output stage.
    always_comb begin
        ar_ready_o    = '0;
        stage_in_s    = ar_chan_i[grant_idx_s];
        stage_in_s.id = axi_id_t'(chan_to_id(32'(grant_idx_s)));
        if (grant_hs_s) begin
            ar_ready_o[grant_idx_s] = 1'b1;
        end else begin
            ar_ready_o = '0;
        end
    end

    // Pointer moves past the winner only on an accepted grant.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_hs_s) begin
            rr_ptr_d = (32'(grant_idx_s) == NumChannels - 1) ? '0 : grant_idx_s + chan_idx_t'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Retires with an out-of-range ID or against an empty counter are dropped.
    assign retire_s = axi_r_valid_i & axi_r_ready_i & axi_r_last_i
                      & (32'(axi_r_id_i) < NumChannels);

    // Per-channel increment / decrement requests.
    always_comb begin
        inc_s = '0;
        dec_s = '0;
        for (int unsigned i = 0; i < NumChannels; i++) begin
            inc_s[i] = grant_hs_s & (32'(grant_idx_s) == i);
            dec_s[i] = retire_s & (32'(axi_r_id_i) == i) & (cnt_q[i] != '0);
        end
    end

    // Counter next state; simultaneous increment and decrement cancel.
    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < NumChannels; i++) begin
            if (inc_s[i] && !dec_s[i]) begin
                cnt_d[i] = cnt_q[i] + cnt_t'(1);
            end else if (dec_s[i] && !inc_s[i]) begin
                cnt_d[i] = cnt_q[i] - cnt_t'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Pointer and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    idma_desc64_ar_arbiter_spill #(
        .T (axi_ar_chan_t)
    ) i_spill (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (grant_valid_s),
        .ready_o (stage_ready_s),
        .data_i  (stage_in_s),
        .valid_o (axi_ar_valid_o),
        .ready_i (axi_ar_ready_i),
        .data_o  (axi_ar_chan_o)
    );

    assign outstanding_o = cnt_q;
    assign busy_o        = axi_ar_valid_o | (|cnt_q);

endmodule

// File: tb/tb_idma_desc64_ar_arbiter.sv
// Directed bench for idma_desc64_ar_arbiter with 4 channels and a limit of 4.
module tb_idma_desc64_ar_arbiter;
    import idma_desc64_ar_arbiter_pkg::*;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    desc64_ar_chan_t [3:0] ar_chan_i;
    logic [3:0]            ar_valid_i;
    logic [3:0]            ar_ready_o;
    desc64_id_t [3:0]      chan_id_o;
    desc64_ar_chan_t       axi_ar_chan_o;
    logic                  axi_ar_valid_o;
    logic                  axi_ar_ready_i;
    desc64_id_t            axi_r_id_i;
    logic                  axi_r_last_i, axi_r_valid_i, axi_r_ready_i;
    logic [3:0][2:0]       outstanding_o;
    logic                  busy_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int bad_retire   = 0;
    int grant_q[$];
    int grant_cyc_q[$];
    int out_id_q[$];
    int out_addr_q[$];
    int out_cyc_q[$];

    idma_desc64_ar_arbiter #(
        .NumChannels    (4),
        .MaxOutstanding (4)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .ar_chan_i      (ar_chan_i),
        .ar_valid_i     (ar_valid_i),
        .ar_ready_o     (ar_ready_o),
        .chan_id_o      (chan_id_o),
        .axi_ar_chan_o  (axi_ar_chan_o),
        .axi_ar_valid_o (axi_ar_valid_o),
        .axi_ar_ready_i (axi_ar_ready_i),
        .axi_r_id_i     (axi_r_id_i),
        .axi_r_last_i   (axi_r_last_i),
        .axi_r_valid_i  (axi_r_valid_i),
        .axi_r_ready_i  (axi_r_ready_i),
        .outstanding_o  (outstanding_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc = cyc + 1;

    // Handshake log and out-of-range retire flag, sampled mid-cycle.
    always @(negedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (ar_valid_i[i] && ar_ready_o[i]) begin
                grant_q.push_back(i);
                grant_cyc_q.push_back(cyc);
            end
        end
        if (axi_ar_valid_o && axi_ar_ready_i) begin
            out_id_q.push_back(int'(axi_ar_chan_o.id));
            out_addr_q.push_back(int'(axi_ar_chan_o.addr));
            out_cyc_q.push_back(cyc);
        end
        if (rst_ni && axi_r_valid_i && axi_r_ready_i && axi_r_last_i && axi_r_id_i >= 4)
            bad_retire = bad_retire + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run = tests_run + 1;
        if (act !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_r();
        axi_r_valid_i = 1'b0;
        axi_r_ready_i = 1'b0;
        axi_r_last_i  = 1'b0;
        axi_r_id_i    = '0;
    endtask

    task automatic do_reset();
        rst_ni         = 1'b0;
        ar_valid_i     = '0;
        axi_ar_ready_i = 1'b1;
        clear_r();
        for (int i = 0; i < 4; i++) begin
            ar_chan_i[i]      = '0;
            ar_chan_i[i].id   = 4'hF;
            ar_chan_i[i].addr = 32'h1000 * (i + 1);
            ar_chan_i[i].len  = 8'd7;
        end
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        grant_q.delete();
        grant_cyc_q.delete();
        out_id_q.delete();
        out_addr_q.delete();
        out_cyc_q.delete();
    endtask

    initial begin
        logic hs;
        do_reset();

        // Reset state and constant IDs.
        check_eq("rst_valid", axi_ar_valid_o, 1'b0);
        check_eq("rst_ready", ar_ready_o, 4'b0000);
        check_eq("rst_cnt", outstanding_o, 12'h000);
        check_eq("rst_busy", busy_o, 1'b0);
        check_eq("chan_id", chan_id_o, 16'h3210);

        // Single channel 2 up to the outstanding limit.
        ar_valid_i = 4'b0100;
        cycles(6);
        check_eq("single_grants", grant_q.size(), 4);
        check_eq("single_outs", out_id_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check_eq("single_id", (i < out_id_q.size()) ? out_id_q[i] : 99, 2);
        check_eq("single_latency", (out_cyc_q.size() > 0 && grant_cyc_q.size() > 0) ?
                 out_cyc_q[0] - grant_cyc_q[0] : 99, 1);
        check_eq("single_consec", (out_cyc_q.size() == 4) ? out_cyc_q[3] - out_cyc_q[0] : 99, 3);
        check_eq("single_cnt4", outstanding_o[2], 3'd4);
        check_eq("single_stall", ar_ready_o, 4'b0000);
        check_eq("single_busy", busy_o, 1'b1);
        axi_r_valid_i = 1'b1; axi_r_ready_i = 1'b1; axi_r_last_i = 1'b1; axi_r_id_i = 4'd2;
        tick();
        clear_r();
        #1;
        check_eq("retire_cnt3", outstanding_o[2], 3'd3);
        check_eq("retire_reelig", ar_ready_o, 4'b0100);
        tick();
        ar_valid_i = '0;
        check_eq("retire_grant5", grant_q.size(), 5);
        check_eq("retire_cnt4", outstanding_o[2], 3'd4);

        // Fairness with all channels requesting.
        do_reset();
        ar_valid_i = 4'hF;
        cycles(8);
        ar_valid_i = '0;
        cycles(2);
        check_eq("fair_count", grant_q.size(), 8);
        for (int i = 0; i < 8; i++)
            check_eq("fair_grant", (i < grant_q.size()) ? grant_q[i] : 99, i % 4);
        for (int i = 0; i < 8; i++)
            check_eq("fair_out_id", (i < out_id_q.size()) ? out_id_q[i] : 99, i % 4);
        check_eq("fair_cnt", outstanding_o, {3'd2, 3'd2, 3'd2, 3'd2});

        // Backpressure: two entries accepted, output held stable.
        do_reset();
        axi_ar_ready_i    = 1'b0;
        ar_chan_i[0].addr = 32'h100;
        ar_valid_i        = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            #1;
            hs = ar_ready_o[0];
            if (c > 0) check_eq("bp_hold_addr", axi_ar_chan_o.addr, 32'h100);
            tick();
            if (hs) ar_chan_i[0].addr = ar_chan_i[0].addr + 32'd1;
        end
        ar_valid_i = '0;
        check_eq("bp_grants", grant_q.size(), 2);
        check_eq("bp_valid", axi_ar_valid_o, 1'b1);
        axi_ar_ready_i = 1'b1;
        cycles(3);
        check_eq("bp_outs", out_addr_q.size(), 2);
        check_eq("bp_first", (out_addr_q.size() > 0) ? out_addr_q[0] : 0, 32'h100);
        check_eq("bp_second", (out_addr_q.size() > 1) ? out_addr_q[1] : 0, 32'h101);
        check_eq("bp_drained", axi_ar_valid_o, 1'b0);

        // Grant and retire on the same channel in one cycle.
        do_reset();
        ar_valid_i = 4'b0010;
        cycles(3);
        check_eq("sim_pre", outstanding_o[1], 3'd3);
        axi_r_valid_i = 1'b1; axi_r_ready_i = 1'b1; axi_r_last_i = 1'b1; axi_r_id_i = 4'd1;
        tick();
        ar_valid_i = '0;
        clear_r();
        check_eq("sim_cnt", outstanding_o[1], 3'd3);
        check_eq("sim_grants", grant_q.size(), 4);

        // Non-last beats, unaccepted last, bad ID, empty-counter retire.
        axi_r_valid_i = 1'b1; axi_r_ready_i = 1'b1; axi_r_last_i = 1'b0; axi_r_id_i = 4'd1;
        cycles(2);
        axi_r_last_i = 1'b1; axi_r_ready_i = 1'b0;
        cycles(1);
        check_eq("nonlast_cnt", outstanding_o[1], 3'd3);
        axi_r_ready_i = 1'b1; axi_r_id_i = 4'd7;
        tick();
        clear_r();
        check_eq("badid_cnt", outstanding_o, {3'd0, 3'd0, 3'd3, 3'd0});
        check_eq("badid_flag", bad_retire, 1);
        axi_r_valid_i = 1'b1; axi_r_ready_i = 1'b1; axi_r_last_i = 1'b1; axi_r_id_i = 4'd1;
        tick();
        axi_r_id_i = 4'd0;
        tick();
        clear_r();
        check_eq("retire_and_zero", outstanding_o, {3'd0, 3'd0, 3'd2, 3'd0});

        // Asynchronous reset mid-burst with counts {2,1,0,4}.
        do_reset();
        ar_valid_i = 4'b1000;
        cycles(4);
        ar_valid_i = 4'b0010;
        cycles(1);
        ar_valid_i = '0;
        cycles(2);
        axi_ar_ready_i = 1'b0;
        ar_valid_i     = 4'b0001;
        cycles(2);
        ar_valid_i = '0;
        check_eq("pre_rst_cnt", outstanding_o, {3'd4, 3'd0, 3'd1, 3'd2});
        check_eq("pre_rst_valid", axi_ar_valid_o, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("arst_cnt", outstanding_o, 12'h000);
        check_eq("arst_valid", axi_ar_valid_o, 1'b0);
        check_eq("arst_busy", busy_o, 1'b0);
        cycles(2);
        rst_ni         = 1'b1;
        axi_ar_ready_i = 1'b1;
        ar_valid_i     = 4'hF;
        #1;
        check_eq("post_rst_ready", ar_ready_o, 4'b0001);
        tick();
        ar_valid_i = '0;
        check_eq("post_rst_valid", axi_ar_valid_o, 1'b1);
        check_eq("post_rst_id", axi_ar_chan_o.id, 4'd0);
        check_eq("post_rst_cnt0", outstanding_o, {3'd0, 3'd0, 3'd0, 3'd1});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
